// File: rtl/frame_sync_if.sv
// Bit-serial receive bundle between the front end (master) and the frame
// synchroniser (slave), carrying the lock/framing status back.
interface frame_sync_if #(
  parameter int FRAME_LEN = 16
);
  localparam int BPW = $clog2(FRAME_LEN);

  // s_valid qualifies s_in for exactly one bit per cycle; there is no
  // backpressure, so the receiver consumes every qualified bit.
  logic           s_in;
  logic           s_valid;
  logic           valido;
  logic           frame_start;
  logic           sync_err;
  logic [BPW-1:0] bit_pos;
  logic [1:0]     state;

  modport master (
    output s_in, s_valid,
    input  valido, frame_start, sync_err, bit_pos, state
  );

  modport slave (
    input  s_in, s_valid,
    output valido, frame_start, sync_err, bit_pos, state
  );
endinterface

// File: rtl/frame_sync_det.sv
// Serial frame synchroniser: hunts for SYNC_PAT, confirms it at fixed frame
// spacing before locking, flywheels over isolated bad sync words.
module frame_sync_det #(
  parameter int             N          = 5,
  parameter logic [N-1:0]   SYNC_PAT   = 5'b10100,
  parameter logic [N-1:0]   RESET_PAT  = 5'b00000,
  parameter int             FRAME_LEN  = 16,
  parameter int             LOCK_CNT   = 3,
  parameter int             UNLOCK_CNT = 2
) (
  input  logic         clk,
  input  logic         rst,
  frame_sync_if.slave  sif
);
  localparam int BPW = $clog2(FRAME_LEN);
  localparam int HW  = $clog2(LOCK_CNT + 1);
  localparam int MW  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    PRESYNC = 2'b01,
    SYNC    = 2'b10,
    LOSS    = 2'b11
  } state_t;

  state_t         state_q, state_n;
  logic [N-2:0]   sr_q, sr_n;
  logic [BPW-1:0] bit_pos_q, bit_pos_n;
  logic [HW-1:0]  hit_q, hit_n, hit_inc;
  logic [MW-1:0]  miss_q, miss_n, miss_inc;
  logic           fs_q, fs_n;
  logic           se_q, se_n;

  logic [N-1:0]   w;
  logic           ckpt, sync_hit, rst_hit;

  // Only the newest N-1 bits need storing; the window adds the incoming bit.
  assign w        = {sr_q, sif.s_in};
  assign sync_hit = (w == SYNC_PAT);
  assign rst_hit  = (w == RESET_PAT);
  assign ckpt     = (bit_pos_q == BPW'(FRAME_LEN - 1));
  assign hit_inc  = hit_q + HW'(1);
  assign miss_inc = miss_q + MW'(1);

  always_comb begin
    state_n   = state_q;
    sr_n      = sr_q;
    bit_pos_n = bit_pos_q;
    hit_n     = hit_q;
    miss_n    = miss_q;
    fs_n      = 1'b0;
    se_n      = 1'b0;
    if (sif.s_valid) begin
      sr_n      = w[N-2:0];
      bit_pos_n = ckpt ? '0 : bit_pos_q + BPW'(1);
      case (state_q)
        HUNT: begin
          if (sync_hit) begin
            bit_pos_n = '0;
            hit_n     = HW'(1);
            if (LOCK_CNT == 1) begin
              state_n = SYNC;
              fs_n    = 1'b1;
              miss_n  = '0;
            end else begin
              state_n = PRESYNC;
            end
          end
        end
        PRESYNC: begin
          if (ckpt) begin
            if (sync_hit) begin
              hit_n = hit_inc;
              if (hit_inc == HW'(LOCK_CNT)) begin
                state_n = SYNC;
                fs_n    = 1'b1;
                miss_n  = '0;
              end
            end else begin
              state_n = HUNT;
              hit_n   = '0;
            end
          end
        end
        default: begin
          // Reset pattern wins over a coincident checkpoint evaluation.
          if (rst_hit) begin
            state_n = HUNT;
            hit_n   = '0;
            miss_n  = '0;
          end else if (ckpt) begin
            if (sync_hit) begin
              state_n = SYNC;
              miss_n  = '0;
              fs_n    = 1'b1;
            end else begin
              se_n = 1'b1;
              if (miss_inc == MW'(UNLOCK_CNT)) begin
                state_n = HUNT;
                hit_n   = '0;
                miss_n  = '0;
              end else begin
                state_n = LOSS;
                miss_n  = miss_inc;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_pos_q <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      fs_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      sr_q      <= sr_n;
      bit_pos_q <= bit_pos_n;
      hit_q     <= hit_n;
      miss_q    <= miss_n;
      fs_q      <= fs_n;
      se_q      <= se_n;
    end
  end

  assign sif.state       = state_q;
  assign sif.valido      = (state_q == SYNC) || (state_q == LOSS);
  assign sif.frame_start = fs_q;
  assign sif.sync_err    = se_q;
  assign sif.bit_pos     = bit_pos_q;
endmodule

// File: tb/tb_frame_sync_det.sv
// Randomised/directed bench for frame_sync_det against a bit-history
// reference model of the synchroniser rules.
module tb_frame_sync_det;
  localparam int N          = 5;
  localparam int FRAME_LEN  = 16;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;
  localparam int BPW        = $clog2(FRAME_LEN);
  localparam int W          = 5 + BPW;
  localparam logic [N-1:0] SYNC_PAT  = 5'b10100;
  localparam logic [N-1:0] RESET_PAT = 5'b00000;
  localparam logic [10:0]  PAYLOAD   = 11'b01101011011;
  localparam logic [N-1:0] BAD_PAT   = 5'b10110;

  logic clk;
  logic rst;

  frame_sync_if #(.FRAME_LEN(FRAME_LEN)) sif ();

  frame_sync_det #(
    .N(N), .SYNC_PAT(SYNC_PAT), .RESET_PAT(RESET_PAT),
    .FRAME_LEN(FRAME_LEN), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int gap_pct = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: keeps the raw accepted-bit history and applies the
  // framing rules per accepted bit
  bit m_hist[$];
  int m_state, m_bp, m_hit, m_miss;
  bit m_fs, m_se;

  task automatic model_step(input logic b, input logic v, input logic r);
    int  w;
    bit  ck, sm, rm;
    m_fs = 1'b0;
    m_se = 1'b0;
    if (!r) begin
      m_state = 0; m_bp = 0; m_hit = 0; m_miss = 0;
      m_hist.delete();
    end else if (v) begin
      m_hist.push_back(b);
      if (m_hist.size() > N) void'(m_hist.pop_front());
      w = 0;
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = m_hist.size() - N + i;
        w = (w << 1) | ((idx >= 0) ? int'(m_hist[idx]) : 0);
      end
      ck = (m_bp == FRAME_LEN - 1);
      sm = (w == int'(SYNC_PAT));
      rm = (w == int'(RESET_PAT));
      m_bp = ck ? 0 : m_bp + 1;
      case (m_state)
        0: if (sm) begin
          m_bp = 0; m_hit = 1;
          if (LOCK_CNT == 1) begin m_state = 2; m_fs = 1'b1; m_miss = 0; end
          else m_state = 1;
        end
        1: if (ck) begin
          if (sm) begin
            m_hit++;
            if (m_hit == LOCK_CNT) begin m_state = 2; m_fs = 1'b1; m_miss = 0; end
          end else begin
            m_state = 0; m_hit = 0;
          end
        end
        default: begin
          if (rm) begin
            m_state = 0; m_hit = 0; m_miss = 0;
          end else if (ck) begin
            if (sm) begin
              m_state = 2; m_miss = 0; m_fs = 1'b1;
            end else begin
              m_se = 1'b1;
              m_miss++;
              if (m_miss >= UNLOCK_CNT) begin m_state = 0; m_hit = 0; m_miss = 0; end
              else m_state = 3;
            end
          end
        end
      endcase
    end
    exp_q.push_back({2'(m_state), (m_state >= 2) ? 1'b1 : 1'b0, m_fs, m_se, BPW'(m_bp)});
  endtask

  // driver: inputs change 1ns after the edge, outputs checked there too
  task automatic cycle(input logic b, input logic v, input logic r);
    logic [W-1:0] e;
    sif.s_in    = b;
    sif.s_valid = v;
    rst         = r;
    @(posedge clk);
    model_step(b, v, r);
    #1;
    e = exp_q.pop_front();
    check("state",       int'(sif.state),       int'(e[W-1:W-2]));
    check("valido",      int'(sif.valido),      int'(e[W-3]));
    check("frame_start", int'(sif.frame_start), int'(e[W-4]));
    check("sync_err",    int'(sif.sync_err),    int'(e[W-5]));
    check("bit_pos",     int'(sif.bit_pos),     int'(e[BPW-1:0]));
  endtask

  task automatic send(input logic b);
    for (int k = 0; k < 20 && $urandom_range(99) < gap_pct; k++)
      cycle(1'($urandom_range(1)), 1'b0, 1'b1);
    cycle(b, 1'b1, 1'b1);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic send_frame(input logic [N-1:0] tail);
    send_bits({5'b0, PAYLOAD}, 11);
    send_bits({11'b0, tail}, N);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(1'($urandom_range(1)), 1'b1, 1'b0);
  endtask

  task automatic lock_seq(input string tag);
    send_bits({11'b0, SYNC_PAT}, N);
    check({tag, "_presync"}, int'(sif.state), 1);
    send_frame(SYNC_PAT);
    send_frame(SYNC_PAT);
    check({tag, "_locked"}, int'(sif.state), 2);
    check({tag, "_fs"}, int'(sif.frame_start), 1);
    check({tag, "_bitpos"}, int'(sif.bit_pos), 0);
  endtask

  initial begin
    sif.s_in = 1'b0;
    sif.s_valid = 1'b0;
    rst = 1'b0;

    do_reset();
    check("reset_state", int'(sif.state), 0);
    check("reset_valido", int'(sif.valido), 0);

    lock_seq("lock");

    // flywheel over one bad sync word
    send_frame(BAD_PAT);
    check("fly_err", int'(sif.sync_err), 1);
    check("fly_loss", int'(sif.state), 3);
    check("fly_valido", int'(sif.valido), 1);
    send_frame(SYNC_PAT);
    check("fly_recover", int'(sif.state), 2);

    // two bad sync words drop lock
    send_frame(BAD_PAT);
    send_frame(BAD_PAT);
    check("loss_err", int'(sif.sync_err), 1);
    check("loss_hunt", int'(sif.state), 0);
    check("loss_valido", int'(sif.valido), 0);

    // relock, then a reset pattern in the payload
    lock_seq("relock");
    send_bits(16'b0110100000, 10);
    check("rpat_hunt", int'(sif.state), 0);
    check("rpat_noerr", int'(sif.sync_err), 0);
    send(1'b1);

    // lock with input gaps, then reset mid-frame while locked
    gap_pct = 30;
    do_reset();
    lock_seq("gap");
    send_bits(16'b0110, 4);
    cycle(1'b1, 1'b1, 1'b0);
    check("midrst_state", int'(sif.state), 0);
    check("midrst_bitpos", int'(sif.bit_pos), 0);

    // random frames: mostly good sync words, some bad/reset/slipped
    gap_pct = 20;
    for (int f = 0; f < 150; f++) begin
      int sel;
      for (int i = 0; i < FRAME_LEN - N; i++) send(1'($urandom_range(1)));
      sel = $urandom_range(99);
      if (sel < 70)      send_bits({11'b0, SYNC_PAT}, N);
      else if (sel < 85) send_bits(16'($urandom_range(31)), N);
      else if (sel < 92) send_bits({11'b0, RESET_PAT}, N);
      else               send_bits(16'($urandom_range(63)), N + 1);
      if ($urandom_range(199) == 0) cycle(1'b0, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_sync_det.md
Name: frame_sync_det

Overview:
Serial frame synchroniser, the parametrised successor of the single-pattern detector. It hunts for a configurable N-bit sync pattern on a bit-serial stream and confirms it at fixed frame spacing over LOCK_CNT frames before declaring lock. While locked it tolerates up to UNLOCK_CNT-1 consecutive bad sync words (flywheel) and drops lock on an explicit reset pattern. It sits between the serial receive front end and the frame deserialiser, and provides lock status, a frame-start strobe and the bit position within the frame.

Parameters:
N, 5, sync/reset pattern width in bits (>=2)
SYNC_PAT, 5'b10100, sync word; MSB is the first bit received
RESET_PAT, 5'b00000, forces immediate loss of lock while locked; must differ from SYNC_PAT
FRAME_LEN, 16, accepted bits from one sync-word end to the next (>=N)
LOCK_CNT, 3, total consecutive good sync words needed to lock (>=1)
UNLOCK_CNT, 2, consecutive bad sync words needed to drop lock (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
s_in  in  1  serial data bit
s_valid  in  1  s_in is accepted this cycle; the block is frozen when low
valido  out  1  lock indication (state SYNC or LOSS)
frame_start  out  1  one-cycle strobe, good sync word confirmed
sync_err  out  1  one-cycle strobe, bad sync word while locked
bit_pos  out  $clog2(FRAME_LEN)  accepted bits since the last sync-word end
state  out  2  00 HUNT, 01 PRESYNC, 10 SYNC, 11 LOSS

Behaviour:
- Reset (rst=0 at clk edge): state=HUNT, shift reg sr=0, bit_pos=0, hit/miss counters=0, valido=0, frame_start=0, sync_err=0. Reset mid-frame or while locked has the same effect; lock is lost at once.
- Window w = {sr[N-2:0], s_in}, combinational. On s_valid: sr<=w. All decisions below use w and take effect only on s_valid cycles.
- Every output is registered. Response appears the cycle after the deciding bit is accepted (1-cycle latency).
- bit_pos: on s_valid, increments. Checkpoint = s_valid & bit_pos==FRAME_LEN-1; at a checkpoint bit_pos<=0. A HUNT match also sets bit_pos<=0.
- HUNT: w==SYNC_PAT -> PRESYNC, hit=1, bit_pos<=0. If LOCK_CNT==1, go directly to SYNC and pulse frame_start. Every accepted bit is examined. RESET_PAT is ignored.
- PRESYNC: only checkpoints are evaluated. Match -> hit+1; if hit+1==LOCK_CNT -> SYNC, frame_start pulse, miss=0. Mismatch -> HUNT, hit=0. That window is not re-hunted; hunting restarts on the next bit. RESET_PAT is ignored.
- SYNC: checkpoint match -> stay, frame_start pulse. Mismatch -> sync_err pulse, miss=1, next state LOSS (HUNT if UNLOCK_CNT==1).
- LOSS: valido stays 1. Checkpoint match -> SYNC, miss=0, frame_start pulse. Mismatch -> sync_err pulse, miss+1; if miss+1==UNLOCK_CNT -> HUNT.
- SYNC/LOSS, any s_valid cycle with w==RESET_PAT -> HUNT, hit=miss=0, no sync_err. This takes priority over the checkpoint evaluation in the same cycle.
- valido = (state==SYNC || state==LOSS), taken from the state register.
- s_valid=0: sr, bit_pos, state and counters hold. frame_start and sync_err are 0.
- Counters saturate by construction (LOCK_CNT/UNLOCK_CNT compare). Widths are $clog2(param+1).
- Unused encodings are not reachable. If reached, the block recovers to HUNT on the next clock.

Test Plan:
(Defaults. Frame = 11 payload bits 01101011011 + 10100. This payload contains neither pattern, including across frame boundaries.)
1. Reset: rst=0 for 3 cycles with random s_in/s_valid=1 -> valido=0, state=00, bit_pos=0, no strobes.
2. Lock: bits 10100 then 2 frames -> state=01 the cycle after the first pattern's last bit. state=10, valido=1 and frame_start=1 the cycle after the 3rd pattern's last bit. bit_pos=0 then.
3. Flywheel: locked, send one frame ending 10110, then a good frame -> sync_err=1, state=11, valido=1; then frame_start=1, state=10.
4. Loss: locked, two consecutive frames ending 10110 -> second sync_err, state=00, valido=0 one cycle after the second bad checkpoint. A later 10100 gives state=01.
5. Reset pattern: locked, payload bits 5..9 = 00000 -> state=00, valido=0 one cycle after the 5th zero. No sync_err.
6. Gaps/reset: repeat test 2 with s_valid low on random 30% of cycles -> identical state/bit_pos sequence per accepted bit. Assert rst=0 mid-frame while locked -> all outputs return to reset values next cycle.
